// File: rtl/scene_renderer_if.sv
// Pixel-stream and game-state bundle between the VGA/game side and scene_renderer.
// The master drives pixel coordinates and game state; the slave returns colour and pipe positions.
interface scene_renderer_if;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic       vsync;
    logic [9:0] bird_y;
    logic [9:0] gap_y0;
    logic [9:0] gap_y1;
    logic       run;
    logic       game_over;
    logic [2:0] rgb;
    logic       frame_tick;
    logic [9:0] pipe_x0;
    logic [9:0] pipe_x1;

    modport master (
        output x_pos, y_pos, vsync, bird_y, gap_y0, gap_y1, run, game_over,
        input  rgb, frame_tick, pipe_x0, pipe_x1
    );

    modport slave (
        input  x_pos, y_pos, vsync, bird_y, gap_y0, gap_y1, run, game_over,
        output rgb, frame_tick, pipe_x0, pipe_x1
    );
endinterface

// File: rtl/scene_renderer.sv
// Per-pixel flappy bird scene generator: latches game state on each vsync rising edge,
// scrolls two pipes, and renders bird/pipes/ground/background through a 2-stage pipeline.
module scene_renderer #(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned BIRD_X       = 160,
    parameter int unsigned BIRD_SIZE    = 20,
    parameter int unsigned PIPE_W       = 60,
    parameter int unsigned GAP_H        = 120,
    parameter int unsigned PIPE_SPACING = 320,
    parameter int unsigned SCROLL_STEP  = 2,
    parameter int unsigned GROUND_Y     = 440
) (
    input logic             clk,
    input logic             rst,
    scene_renderer_if.slave bus
);

    localparam logic [10:0] H_LIM     = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIM     = 11'(V_ACTIVE);
    localparam logic [10:0] BIRD_L    = 11'(BIRD_X);
    localparam logic [10:0] BIRD_R    = 11'(BIRD_X + BIRD_SIZE);
    localparam logic [10:0] BIRD_SZ   = 11'(BIRD_SIZE);
    localparam logic [10:0] PIPE_WD   = 11'(PIPE_W);
    localparam logic [10:0] GAP_HT    = 11'(GAP_H);
    localparam logic [10:0] GROUND    = 11'(GROUND_Y);
    localparam logic [9:0]  STEP      = 10'(SCROLL_STEP);
    localparam logic [10:0] WRAP_ADD  = 11'(2 * PIPE_SPACING - SCROLL_STEP);
    localparam logic [9:0]  PIPE0_RST = 10'(PIPE_SPACING - 1);
    localparam logic [9:0]  PIPE1_RST = 10'(2 * PIPE_SPACING - 1);

    logic       vs_prev;
    logic       tick_edge;
    logic       frame_tick_r;
    logic [9:0] bird_y_l, gap_y0_l, gap_y1_l;
    logic       run_l, game_over_l;
    logic [9:0] pipe_x0_r, pipe_x1_r;

    assign tick_edge = bus.vsync & ~vs_prev;

    // Left edge moves by one step per running frame; falling below zero re-enters at the far end.
    function automatic logic [9:0] scroll(input logic [9:0] px);
        if (px >= STEP) return px - STEP;
        return 10'({1'b0, px} + WRAP_ADD);
    endfunction

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_prev      <= 1'b1;
            frame_tick_r <= 1'b0;
            bird_y_l     <= 10'd240;
            gap_y0_l     <= 10'd180;
            gap_y1_l     <= 10'd180;
            run_l        <= 1'b0;
            game_over_l  <= 1'b0;
            pipe_x0_r    <= PIPE0_RST;
            pipe_x1_r    <= PIPE1_RST;
        end else begin
            vs_prev      <= bus.vsync;
            frame_tick_r <= tick_edge;
            if (tick_edge) begin
                bird_y_l    <= bus.bird_y;
                gap_y0_l    <= bus.gap_y0;
                gap_y1_l    <= bus.gap_y1;
                run_l       <= bus.run;
                game_over_l <= bus.game_over;
                if (bus.run) begin
                    pipe_x0_r <= scroll(pipe_x0_r);
                    pipe_x1_r <= scroll(pipe_x1_r);
                end
            end
        end
    end

    // Stage 1: hit tests on 11-bit operands so coordinate + size never overflows.
    logic [10:0] x, y;
    logic        hit_blank, hit_bird, hit_pipe, hit_ground;

    assign x = {1'b0, bus.x_pos};
    assign y = {1'b0, bus.y_pos};

    function automatic logic pipe_hit(input logic [10:0] px, input logic [10:0] gy,
                                      input logic [10:0] cx, input logic [10:0] cy);
        return (cx >= px) && (cx < px + PIPE_WD) &&
               ((cy < gy) || (cy >= gy + GAP_HT)) && (cy < GROUND);
    endfunction

    assign hit_blank  = (x >= H_LIM) || (y >= V_LIM);
    assign hit_bird   = (x >= BIRD_L) && (x < BIRD_R) &&
                        (y >= {1'b0, bird_y_l}) && (y < {1'b0, bird_y_l} + BIRD_SZ);
    assign hit_pipe   = pipe_hit({1'b0, pipe_x0_r}, {1'b0, gap_y0_l}, x, y) ||
                        pipe_hit({1'b0, pipe_x1_r}, {1'b0, gap_y1_l}, x, y);
    assign hit_ground = (y >= GROUND);

    logic s1_valid, s1_blank, s1_bird, s1_pipe, s1_ground, s1_game_over;
    logic [2:0] colour, rgb_r;

    // NOTE: pipeline registers are reset (unlike a RAM) so rgb is a defined 0 while the pipe refills.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_blank     <= 1'b0;
            s1_bird      <= 1'b0;
            s1_pipe      <= 1'b0;
            s1_ground    <= 1'b0;
            s1_game_over <= 1'b0;
            rgb_r        <= 3'b000;
        end else begin
            s1_valid     <= 1'b1;
            s1_blank     <= hit_blank;
            s1_bird      <= hit_bird;
            s1_pipe      <= hit_pipe;
            s1_ground    <= hit_ground;
            s1_game_over <= game_over_l;
            rgb_r        <= colour;
        end
    end

    // Stage 2: priority colour mux, first match wins.
    always_comb begin
        colour = 3'b000;
        if (!s1_valid || s1_blank) colour = 3'b000;
        else if (s1_bird)          colour = 3'b110;
        else if (s1_pipe)          colour = 3'b010;
        else if (s1_ground)        colour = 3'b100;
        else if (s1_game_over)     colour = 3'b101;
        else                       colour = 3'b001;
    end

    assign bus.rgb        = rgb_r;
    assign bus.frame_tick = frame_tick_r;
    assign bus.pipe_x0    = pipe_x0_r;
    assign bus.pipe_x1    = pipe_x1_r;

endmodule

// File: tb/tb_scene_renderer.sv
// Randomised self-checking bench for scene_renderer against a rule-level scene model.
module tb_scene_renderer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scene_renderer_if bus ();

    scene_renderer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model of the latched scene: what the renderer should be drawing right now.
    int m_bird, m_gap0, m_gap1, m_go, m_px0, m_px1;

    function automatic logic [2:0] model_rgb(input int x, input int y);
        bit in_p0, in_p1;
        if (x >= 640 || y >= 480) return 3'b000;
        if (x >= 160 && x < 180 && y >= m_bird && y < m_bird + 20) return 3'b110;
        in_p0 = (x >= m_px0 && x < m_px0 + 60 && (y < m_gap0 || y >= m_gap0 + 120) && y < 440);
        in_p1 = (x >= m_px1 && x < m_px1 + 60 && (y < m_gap1 || y >= m_gap1 + 120) && y < 440);
        if (in_p0 || in_p1) return 3'b010;
        if (y >= 440) return 3'b100;
        return m_go ? 3'b101 : 3'b001;
    endfunction

    task automatic model_reset();
        m_bird = 240; m_gap0 = 180; m_gap1 = 180; m_go = 0;
        m_px0 = 319; m_px1 = 639;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.vsync = 1'b0;
        step(); step(); step();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic run_pixel(input int x, input int y, output logic [2:0] got);
        bus.x_pos = 10'(x);
        bus.y_pos = 10'(y);
        step();
        step();
        got = bus.rgb;
    endtask

    // One vsync pulse held high 3 cycles; reports how many cycles frame_tick was seen high.
    task automatic do_tick(input int by, input int g0, input int g1, input bit r, input bit go,
                           output int ticks, output bit first_hi);
        bus.bird_y = 10'(by); bus.gap_y0 = 10'(g0); bus.gap_y1 = 10'(g1);
        bus.run = r; bus.game_over = go;
        ticks = 0;
        bus.vsync = 1'b1;
        step();
        first_hi = bus.frame_tick;
        if (bus.frame_tick) ticks++;
        m_bird = by; m_gap0 = g0; m_gap1 = g1; m_go = go;
        if (r) begin
            m_px0 = (m_px0 + 640 - 2) % 640;
            m_px1 = (m_px1 + 640 - 2) % 640;
        end
        for (int i = 0; i < 2; i++) begin
            step();
            if (bus.frame_tick) ticks++;
        end
        bus.vsync = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (bus.frame_tick) ticks++;
        end
    endtask

    task automatic test_reset();
        logic [2:0] got;
        apply_reset();
        checks++;
        if (bus.rgb !== 3'b000) begin
            errors++; $display("FAIL reset_rgb: got %b want 000", bus.rgb);
        end
        checks++;
        if (bus.frame_tick !== 1'b0) begin
            errors++; $display("FAIL reset_tick: got %b want 0", bus.frame_tick);
        end
        checks++;
        if (bus.pipe_x0 !== 10'd319 || bus.pipe_x1 !== 10'd639) begin
            errors++; $display("FAIL reset_pipes: got %0d/%0d want 319/639", bus.pipe_x0, bus.pipe_x1);
        end
        run_pixel(0, 0, got);
        checks++;
        if (got !== 3'b001) begin
            errors++; $display("FAIL reset_pixel00: got %b want 001", got);
        end
    endtask

    task automatic test_first_tick();
        int ticks; bit first_hi;
        logic [2:0] got;
        do_tick(100, 180, 180, 1'b1, 1'b0, ticks, first_hi);
        checks++;
        if (ticks != 1 || !first_hi) begin
            errors++; $display("FAIL first_tick_pulse: got %0d pulses (first=%0d) want 1", ticks, first_hi);
        end
        checks++;
        if (bus.pipe_x0 !== 10'd317 || bus.pipe_x1 !== 10'd637) begin
            errors++; $display("FAIL first_tick_pipes: got %0d/%0d want 317/637", bus.pipe_x0, bus.pipe_x1);
        end
        run_pixel(165, 110, got);
        checks++;
        if (got !== 3'b110 || got !== model_rgb(165, 110)) begin
            errors++; $display("FAIL bird_pixel: got %b want 110", got);
        end
        run_pixel(165, 99, got);
        checks++;
        if (got !== 3'b001 || got !== model_rgb(165, 99)) begin
            errors++; $display("FAIL above_bird_pixel: got %b want 001", got);
        end
    endtask

    task automatic test_scroll_wrap();
        int ticks; bit first_hi;
        for (int n = 0; n < 330; n++) begin
            do_tick(100, 180, 180, 1'b1, 1'b0, ticks, first_hi);
            checks++;
            if (bus.pipe_x0 !== 10'(m_px0) || bus.pipe_x1 !== 10'(m_px1)) begin
                errors++;
                $display("FAIL scroll_tick%0d: got %0d/%0d want %0d/%0d",
                         n, bus.pipe_x0, bus.pipe_x1, m_px0, m_px1);
            end
        end
        // Spacing between the pipes is preserved modulo the full loop.
        checks++;
        if (((int'(bus.pipe_x1) - int'(bus.pipe_x0) + 640) % 640) != 320) begin
            errors++; $display("FAIL scroll_spacing: got %0d/%0d want 320 apart", bus.pipe_x0, bus.pipe_x1);
        end
    endtask

    task automatic test_pipes();
        int px[4] = '{330, 330, 330, 700};
        int py[4] = '{50, 200, 450, 10};
        logic [2:0] want[4] = '{3'b010, 3'b001, 3'b100, 3'b000};
        logic [2:0] got;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            run_pixel(px[i], py[i], got);
            checks++;
            if (got !== want[i] || got !== model_rgb(px[i], py[i])) begin
                errors++; $display("FAIL pipe_pixel(%0d,%0d): got %b want %b", px[i], py[i], got, want[i]);
            end
        end
    endtask

    task automatic test_game_over();
        int ticks; bit first_hi;
        logic [2:0] got;
        bus.game_over = 1'b1;
        bus.run = 1'b0;
        run_pixel(50, 50, got);
        checks++;
        if (got !== 3'b001) begin
            errors++; $display("FAIL game_over_early: got %b want 001", got);
        end
        do_tick(240, 180, 180, 1'b0, 1'b1, ticks, first_hi);
        run_pixel(50, 50, got);
        checks++;
        if (got !== 3'b101 || got !== model_rgb(50, 50)) begin
            errors++; $display("FAIL game_over_tint: got %b want 101", got);
        end
        run_pixel(165, 245, got);
        checks++;
        if (got !== 3'b110) begin
            errors++; $display("FAIL game_over_bird: got %b want 110", got);
        end
        checks++;
        if (bus.pipe_x0 !== 10'd319 || bus.pipe_x1 !== 10'd639) begin
            errors++; $display("FAIL run0_hold: got %0d/%0d want 319/639", bus.pipe_x0, bus.pipe_x1);
        end
    endtask

    task automatic test_random_stream();
        int ticks; bit first_hi;
        int xs[$], ys[$];
        logic [2:0] exp_q[$];
        for (int round = 0; round < 8; round++) begin
            do_tick($urandom_range(0, 500), $urandom_range(0, 400), $urandom_range(0, 400),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ticks, first_hi);
            for (int k = 0; k < 1 + $urandom_range(0, 40); k++)
                do_tick(100, 180, 180, 1'b1, m_go != 0, ticks, first_hi);
            // Unlatched changes must not reach the picture.
            bus.bird_y = 10'($urandom); bus.gap_y0 = 10'($urandom); bus.gap_y1 = 10'($urandom);
            bus.game_over = ~bus.game_over; bus.run = 1'($urandom);
            xs.delete(); ys.delete(); exp_q.delete();
            for (int i = 0; i <= 60; i++) begin
                if (i < 60) begin
                    int x, y;
                    x = (i % 3 == 0) ? $urandom_range(150, 400) : $urandom_range(0, 799);
                    y = $urandom_range(0, 524);
                    bus.x_pos = 10'(x); bus.y_pos = 10'(y);
                    xs.push_back(x); ys.push_back(y); exp_q.push_back(model_rgb(x, y));
                end
                step();
                if (i >= 1) begin
                    checks++;
                    if (bus.rgb !== exp_q[i-1]) begin
                        errors++;
                        $display("FAIL stream r%0d (%0d,%0d): got %b want %b",
                                 round, xs[i-1], ys[i-1], bus.rgb, exp_q[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_vsync_high();
        int ticks;
        bus.vsync = 1'b1;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        model_reset();
        checks++;
        if (bus.rgb !== 3'b000 || bus.pipe_x0 !== 10'd319 || bus.pipe_x1 !== 10'd639) begin
            errors++; $display("FAIL midreset_state: got rgb=%b pipes=%0d/%0d want 000 319/639",
                               bus.rgb, bus.pipe_x0, bus.pipe_x1);
        end
        bus.x_pos = 10'd10; bus.y_pos = 10'd10;
        ticks = bus.frame_tick ? 1 : 0;
        step();
        checks++;
        if (bus.rgb !== 3'b000) begin
            errors++; $display("FAIL midreset_refill: got %b want 000", bus.rgb);
        end
        for (int i = 0; i < 4; i++) begin
            if (bus.frame_tick) ticks++;
            step();
        end
        checks++;
        if (ticks != 0) begin
            errors++; $display("FAIL midreset_no_tick: got %0d pulses want 0", ticks);
        end
        checks++;
        if (bus.rgb !== model_rgb(10, 10)) begin
            errors++; $display("FAIL midreset_resume: got %b want %b", bus.rgb, model_rgb(10, 10));
        end
        bus.vsync = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.x_pos = '0; bus.y_pos = '0; bus.vsync = 1'b0;
        bus.bird_y = 10'd240; bus.gap_y0 = 10'd180; bus.gap_y1 = 10'd180;
        bus.run = 1'b0; bus.game_over = 1'b0;
        model_reset();
        test_reset();
        test_first_tick();
        test_scroll_wrap();
        test_pipes();
        test_game_over();
        test_random_stream();
        test_reset_vsync_high();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
